turn_sequencer: RTL

Round controller for the human-vs-computer guessing game. Alternates turns between the human move (hMove, committed by enter) and the computer move (cMove), and shares the single move comparator datapath between the two players. Accumulates per-player scores and the round count, and decides the game outcome. Sits between the input and debounce logic and the comparator/display datapath.

---
 rtl/turn_sequencer.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/turn_sequencer.sv
// ============================================================================
// Module   : turn_sequencer
// Brief    : Round controller for the human-vs-computer guessing game; alternates
//            turns over one shared comparator and keeps scores and the round count.
//            Optional human-turn timeout is enabled with `define TURN_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module turn_sequencer #(
    parameter int MAX_ROUNDS     = 8,
    parameter int WIN_SCORE      = 3,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       reset_L,
    input  logic       newGame,
    input  logic       enter,
    input  logic [3:0] hMove,
    input  logic [3:0] cMove,
    input  logic       cmp_done,
    input  logic       match,
    output logic       cmp_start,
    output logic       cmp_sel,
    output logic [3:0] cmp_move,
    output logic [3:0] hScore,
    output logic [3:0] cScore,
    output logic [3:0] round,
    output logic       win,
    output logic       tie,
    output logic       gameOver
`ifdef TURN_TIMEOUT_EN
    ,
    output logic       timeout
`endif
);

    localparam logic [3:0] c_MAX_ROUNDS = 4'(MAX_ROUNDS);
    localparam logic [3:0] c_WIN_SCORE  = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        H_WAIT  = 3'd1,
        H_CMP   = 3'd2,
        C_ISSUE = 3'd3,
        C_CMP   = 3'd4,
        CHECK   = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t     state_q, state_d;
    logic       cmp_start_q, cmp_start_d;
    logic       cmp_sel_q, cmp_sel_d;
    logic [3:0] cmp_move_q, cmp_move_d;
    logic [3:0] hScore_q, hScore_d;
    logic [3:0] cScore_q, cScore_d;
    logic [3:0] round_q, round_d;
    logic       win_q, win_d;
    logic       tie_q, tie_d;
    logic       gameOver_q, gameOver_d;
    logic       w_expired;

`ifdef TURN_TIMEOUT_EN
    localparam int          c_TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TW-1:0] c_TLAST = c_TW'(TIMEOUT_CYCLES - 1);

    logic [c_TW-1:0] tcnt_q, tcnt_d;
    logic            timeout_q, timeout_d;

    assign w_expired = (tcnt_q == c_TLAST);

    // Counts only while staying in H_WAIT, so every entry restarts from zero.
    always_comb begin
        tcnt_d = '0;
        if (state_q == H_WAIT && state_d == H_WAIT && !newGame) begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            tcnt_q    <= tcnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_expired        = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cmp_start_d = 1'b0;
        cmp_sel_d   = cmp_sel_q;
        cmp_move_d  = cmp_move_q;
        hScore_d    = hScore_q;
        cScore_d    = cScore_q;
        round_d     = round_q;
        win_d       = win_q;
        tie_d       = tie_q;
        gameOver_d  = gameOver_q;
`ifdef TURN_TIMEOUT_EN
        timeout_d   = 1'b0;
`endif
        case (state_q)
            IDLE: ;
            H_WAIT: begin
                if (enter) begin
                    cmp_move_d  = hMove;
                    cmp_sel_d   = 1'b0;
                    cmp_start_d = 1'b1;
                    state_d     = H_CMP;
                end else if (w_expired) begin
`ifdef TURN_TIMEOUT_EN
                    timeout_d = 1'b1;
`endif
                    state_d = C_ISSUE;
                end
            end
            H_CMP: begin
                if (cmp_done) begin
                    if (match && hScore_q != 4'hF) hScore_d = hScore_q + 4'd1;
                    state_d = C_ISSUE;
                end
            end
            C_ISSUE: begin
                cmp_move_d  = cMove;
                cmp_sel_d   = 1'b1;
                cmp_start_d = 1'b1;
                state_d     = C_CMP;
            end
            C_CMP: begin
                if (cmp_done) begin
                    if (match && cScore_q != 4'hF) cScore_d = cScore_q + 4'd1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (hScore_q >= c_WIN_SCORE || cScore_q >= c_WIN_SCORE ||
                    round_q == c_MAX_ROUNDS) begin
                    state_d    = DONE;
                    gameOver_d = 1'b1;
                    win_d      = (hScore_q > cScore_q);
                    tie_d      = (hScore_q == cScore_q);
                end else begin
                    round_d = round_q + 4'd1;
                    state_d = H_WAIT;
                end
            end
            DONE: ;
            default: state_d = IDLE;
        endcase

        // Restart overrides everything, including an enter or a compare in flight.
        if (newGame) begin
            state_d     = H_WAIT;
            cmp_start_d = 1'b0;
            hScore_d    = 4'd0;
            cScore_d    = 4'd0;
            round_d     = 4'd1;
            win_d       = 1'b0;
            tie_d       = 1'b0;
            gameOver_d  = 1'b0;
`ifdef TURN_TIMEOUT_EN
            timeout_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= IDLE;
            cmp_start_q <= 1'b0;
            cmp_sel_q   <= 1'b0;
            cmp_move_q  <= 4'd0;
            hScore_q    <= 4'd0;
            cScore_q    <= 4'd0;
            round_q     <= 4'd0;
            win_q       <= 1'b0;
            tie_q       <= 1'b0;
            gameOver_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmp_start_q <= cmp_start_d;
            cmp_sel_q   <= cmp_sel_d;
            cmp_move_q  <= cmp_move_d;
            hScore_q    <= hScore_d;
            cScore_q    <= cScore_d;
            round_q     <= round_d;
            win_q       <= win_d;
            tie_q       <= tie_d;
            gameOver_q  <= gameOver_d;
        end
    end

    assign cmp_start = cmp_start_q;
    assign cmp_sel   = cmp_sel_q;
    assign cmp_move  = cmp_move_q;
    assign hScore    = hScore_q;
    assign cScore    = cScore_q;
    assign round     = round_q;
    assign win       = win_q;
    assign tie       = tie_q;
    assign gameOver  = gameOver_q;

endmodule

`default_nettype wire
